// File: rtl/acq_timing_manager_if.sv
// Signal bundle between the acquisition timing manager and its surroundings.
// The DUT uses the slave view; the driver/sensor side uses the master view.
interface acq_timing_manager_if #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 16
);
  logic                    event_qualifier;
  logic [RATIO_W-1:0]      user_ratio;
  logic [NUM_CH-1:0]       en_bits;
  logic [NUM_CH-1:0]       done_in;
  logic [CNT_W-1:0]        timeout_limit;
  logic                    clear_status;
  logic                    trigger;
  logic [NUM_CH-1:0]       en_out;
  logic                    busy;
  logic                    sched_isr;
  logic [NUM_CH*CNT_W-1:0] ch_time;
  logic [NUM_CH-1:0]       done_mask;
  logic                    timeout_flag;
  logic                    overrun_flag;

  modport slave (
    input  event_qualifier, user_ratio, en_bits, done_in, timeout_limit, clear_status,
    output trigger, en_out, busy, sched_isr, ch_time, done_mask, timeout_flag, overrun_flag
  );

  modport master (
    output event_qualifier, user_ratio, en_bits, done_in, timeout_limit, clear_status,
    input  trigger, en_out, busy, sched_isr, ch_time, done_mask, timeout_flag, overrun_flag
  );
endinterface

// File: rtl/acq_timing_manager.sv
// Divides carrier events into scheduler triggers and runs one latency-capture
// window per trigger over the enabled sensor channels, ending in a sched_isr pulse.
module acq_timing_manager #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acq_timing_manager_if.slave  bus
);

  typedef enum logic {IDLE, ACQ} state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [RATIO_W-1:0] RATIO_ONE = 1;

  state_t                  state, next_state;
  logic [RATIO_W-1:0]      evt_cnt;
  logic                    trigger_q;
  logic                    sched_isr_q;
  logic                    timeout_flag_q;
  logic                    overrun_flag_q;
  logic [NUM_CH-1:0]       pending;
  logic [NUM_CH-1:0]       done_q;
  logic [NUM_CH-1:0]       done_mask_q;
  logic [NUM_CH-1:0]       capture;
  logic [NUM_CH-1:0]       pending_next;
  logic [CNT_W-1:0]        timer;
  logic [NUM_CH*CNT_W-1:0] ch_time_q;
  logic                    start;
  logic                    finish_ok;
  logic                    finish_to;
  logic                    overrun_set;

  assign bus.trigger      = trigger_q;
  assign bus.en_out       = bus.en_bits;
  assign bus.busy         = (state == ACQ);
  assign bus.sched_isr    = sched_isr_q;
  assign bus.ch_time      = ch_time_q;
  assign bus.done_mask    = done_mask_q;
  assign bus.timeout_flag = timeout_flag_q;
  assign bus.overrun_flag = overrun_flag_q;

  // The >= compare lets a lowered ratio take effect on the very next event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt   <= '0;
      trigger_q <= 1'b0;
    end else if (bus.event_qualifier) begin
      if (evt_cnt >= bus.user_ratio) begin
        evt_cnt   <= '0;
        trigger_q <= 1'b1;
      end else begin
        evt_cnt   <= evt_cnt + RATIO_ONE;
        trigger_q <= 1'b0;
      end
    end else begin
      trigger_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Completion is judged on pending after this cycle's captures, so a capture
  // coinciding with the timeout cycle still ends the window normally.
  always_comb begin
    next_state   = state;
    start        = 1'b0;
    finish_ok    = 1'b0;
    finish_to    = 1'b0;
    capture      = '0;
    pending_next = pending;
    case (state)
      IDLE: begin
        if (trigger_q) begin
          next_state = ACQ;
          start      = 1'b1;
        end
      end
      ACQ: begin
        capture      = bus.done_in & ~done_q & pending;
        pending_next = pending & ~capture;
        if (pending_next == '0) begin
          finish_ok  = 1'b1;
          next_state = IDLE;
        end else if ((bus.timeout_limit != '0) && (timer == bus.timeout_limit)) begin
          finish_to  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign overrun_set = trigger_q && (state == ACQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q         <= '0;
      pending        <= '0;
      done_mask_q    <= '0;
      timer          <= '0;
      ch_time_q      <= '0;
      sched_isr_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      overrun_flag_q <= 1'b0;
    end else begin
      done_q      <= bus.done_in;
      sched_isr_q <= finish_ok | finish_to;

      if (start) begin
        pending     <= bus.en_bits;
        done_mask_q <= '0;
        timer       <= '0;
      end else if (state == ACQ) begin
        pending     <= finish_to ? '0 : pending_next;
        done_mask_q <= done_mask_q | capture;
        if (timer != '1) timer <= timer + CNT_ONE;
        // Channels still waiting at timeout are marked with the all-ones sentinel.
        for (int i = 0; i < NUM_CH; i++) begin
          if (capture[i])
            ch_time_q[i*CNT_W +: CNT_W] <= timer;
          else if (finish_to && pending_next[i])
            ch_time_q[i*CNT_W +: CNT_W] <= '1;
        end
      end

      if (finish_to)                      timeout_flag_q <= 1'b1;
      else if (start || bus.clear_status) timeout_flag_q <= 1'b0;

      if (overrun_set)           overrun_flag_q <= 1'b1;
      else if (bus.clear_status) overrun_flag_q <= 1'b0;
    end
  end

endmodule
